serial_sub: RTL and testbench
=============================

Name: serial_sub

Overview:
- Parametrised multi-bit subtractor built on the full-subtractor cell (diff = a^b^c, borrow = ~a&b | ~(a^b)&c).
- Computes a - b - bin over WIDTH bits, processing BPC bits per clock from the LSB up, with a registered borrow chain between slices.
- Uses a start/done handshake, and reports borrow-out and signed overflow.
- Sits in the arithmetic library as the area-cheap sequential alternative to a ripple full_sub chain.

Parameters:
- WIDTH, 8: operand and result width in bits. Must be at least 2.
- BPC, 1: bits processed per clock. Must be at least 1 and must divide WIDTH. Elaboration fails otherwise.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a subtraction; accepted only when ready=1.
- a  input  WIDTH  minuend; sampled on the accepted start.
- b  input  WIDTH  subtrahend; sampled on the accepted start.
- bin  input  1  borrow-in; sampled on the accepted start.
- ready  output  1  high in IDLE.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse when the result is valid.
- diff  output  WIDTH  result; held until the next accepted start.
- borrow  output  1  borrow-out from the MSB; held like diff.
- ovf  output  1  two's-complement overflow; held like diff.

Behaviour:
- Reset (sampled on the clk edge while rst=1):
  - state goes to IDLE; slice counter = 0.
  - diff=0, borrow=0, ovf=0, done=0, busy=0, ready=1.
  - Internal operand and borrow registers are cleared.
  - rst overrides start and overrides any operation in progress.
  - A reset during RUN aborts the operation: no done pulse, outputs are cleared.
- States: IDLE, RUN, DONE.
  - IDLE: if start=1 at an edge, latch a, b, bin into shift registers, clear the counter, clear the diff accumulator, go to RUN. If start=0, stay in IDLE.
  - RUN: each edge consumes the low BPC bits of the a and b shift registers through BPC chained full-subtractor cells. The borrow register is the cell-0 borrow-in; the last cell's borrow is stored back into it. The BPC diff bits enter the top of the diff accumulator, which shifts right by BPC. The counter increments.
  - When the counter reaches N-1 (N = WIDTH/BPC), that edge completes the final slice, writes diff, borrow and ovf, and moves to DONE.
  - DONE: done=1 for exactly this one cycle. The next edge returns to IDLE unconditionally.
- start handling:
  - start is ignored in RUN and DONE; it is not queued.
  - The earliest next start is accepted in the IDLE cycle following DONE.
- Latency:
  - The start edge is edge 0. done is high in the cycle after edge N.
  - Start-to-start throughput is N+2 cycles.
  - BPC=WIDTH gives N=1, so done follows one cycle after entering RUN.
- Arithmetic:
  - Result equals (a - b - bin) mod 2^WIDTH.
  - borrow=1 exactly when a < b + bin, as unsigned values.
  - ovf = (a[MSB] != b[MSB]) & (diff[MSB] != a[MSB]), using the latched operands. bin does not affect the ovf formula beyond its effect on diff.
- Output stability:
  - diff, borrow and ovf change only on the final RUN edge or on reset.
  - They are stable through DONE, IDLE, and the whole next RUN.
- Input stability: a, b and bin may change freely after the accepted start edge.
- Flag exclusivity: busy, done and ready are mutually exclusive, and exactly one is high in every cycle.

Test Plan:
- WIDTH=8, BPC=1: a=0x05, b=0x03, bin=0, pulse start → done in the cycle after edge 8; diff=0x02, borrow=0, ovf=0. ready returns the cycle after done.
- WIDTH=8, BPC=1: a=0x03, b=0x05, bin=0 → diff=0xFE, borrow=1, ovf=0. Then a=0x00, b=0x00, bin=1 → diff=0xFF, borrow=1, ovf=0.
- WIDTH=8, BPC=1: a=0x80, b=0x01, bin=0 → diff=0x7F, borrow=0, ovf=1. Then a=0x7F, b=0xFF → diff=0x80, borrow=1, ovf=1.
- Start during RUN: start a=0x10, b=0x01, then hold start=1 with a=0xFF, b=0x00 for 3 cycles mid-run → single done, diff=0x0F. A second op is accepted only after ready=1.
- Reset mid-op: start a=0x55, b=0x22, assert rst for one edge at count 4 → next cycle ready=1, diff=0, borrow=0, ovf=0, and no done pulse. A fresh start then gives diff=0x33.
- Sweep with BPC=4 and BPC=8 (WIDTH=8): all 8 a/b/bin MSB corner combos plus 1000 random vectors → done latency of 2 and 1 edges respectively. Every result matches the (a-b-bin) reference model, including borrow and ovf.

Source files
------------

// File: rtl/serial_sub_if.sv
// Start/done handshake bundle for serial_sub.
// The requester drives the operands and start. The subtractor returns the status flags and the results.
interface serial_sub_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             ovf;

  modport master (
    output start, a, b, bin,
    input  ready, busy, done, diff, borrow, ovf
  );

  modport slave (
    input  start, a, b, bin,
    output ready, busy, done, diff, borrow, ovf
  );
endinterface

// File: rtl/serial_sub.sv
// Sequential subtractor that computes a - b - bin, BPC bits per clock from the LSB upward.
// A registered borrow links each slice to the next. Results are held until the next accepted start.
module serial_sub #(
  parameter int WIDTH = 8,
  parameter int BPC   = 1
) (
  input  logic         clk,
  input  logic         rst,
  serial_sub_if.slave  bus
);

  localparam int N  = WIDTH / BPC;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if (WIDTH < 2 || BPC < 1 || (WIDTH % BPC) != 0) begin : g_bad_params
    $fatal(1, "serial_sub: WIDTH must be >= 2 and a multiple of BPC >= 1");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sr, b_sr, acc, acc_next;
  logic             brw, a_msb, b_msb;
  logic [BPC-1:0]   slice_d;
  logic             slice_b;

  always_comb begin
    logic c;
    // NOTE: blocking assignments let the borrow ripple through all BPC cells within one clock.
    c       = brw;
    slice_d = '0;
    for (int i = 0; i < BPC; i++) begin
      slice_d[i] = a_sr[i] ^ b_sr[i] ^ c;
      c          = (~a_sr[i] & b_sr[i]) | (~(a_sr[i] ^ b_sr[i]) & c);
    end
    slice_b  = c;
    acc_next = (acc >> BPC) | (WIDTH'(slice_d) << (WIDTH - BPC));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      a_sr       <= '0;
      b_sr       <= '0;
      acc        <= '0;
      brw        <= 1'b0;
      a_msb      <= 1'b0;
      b_msb      <= 1'b0;
      bus.diff   <= '0;
      bus.borrow <= 1'b0;
      bus.ovf    <= 1'b0;
      bus.done   <= 1'b0;
      bus.busy   <= 1'b0;
      bus.ready  <= 1'b1;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          a_sr      <= bus.a;
          b_sr      <= bus.b;
          brw       <= bus.bin;
          a_msb     <= bus.a[WIDTH-1];
          b_msb     <= bus.b[WIDTH-1];
          cnt       <= '0;
          acc       <= '0;
          state     <= RUN;
          bus.ready <= 1'b0;
          bus.busy  <= 1'b1;
        end
        RUN: begin
          a_sr <= a_sr >> BPC;
          b_sr <= b_sr >> BPC;
          brw  <= slice_b;
          acc  <= acc_next;
          cnt  <= cnt + CW'(1);
          if (cnt == CW'(N - 1)) begin
            // Signed overflow is only possible when the operand signs differ.
            bus.diff   <= acc_next;
            bus.borrow <= slice_b;
            bus.ovf    <= (a_msb ^ b_msb) & (acc_next[WIDTH-1] ^ a_msb);
            state      <= DONE;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b1;
          end
        end
        DONE: begin
          state     <= IDLE;
          bus.done  <= 1'b0;
          bus.ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          bus.done  <= 1'b0;
          bus.busy  <= 1'b0;
          bus.ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub.sv
// Scoreboard bench for serial_sub. It drives three instances (BPC = 1, 4, 8 at WIDTH = 8).
// An 8-bit reference model predicts each result, and the bench checks the done latency.
module tb_serial_sub;

  localparam int NDUT = 3;
  localparam int BPCS [NDUT] = '{1, 4, 8};
  localparam int NS   [NDUT] = '{8, 2, 1};

  typedef struct {
    logic [7:0] diff;
    logic       borrow;
    logic       ovf;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  bit   armed = 1'b0;

  logic [NDUT-1:0] st = '0;
  logic [NDUT-1:0] bi = '0;
  logic [7:0]      av [NDUT] = '{default: 8'h00};
  logic [7:0]      bv [NDUT] = '{default: 8'h00};
  wire  [NDUT-1:0] rdy, bsy, dn, bo, ov;
  wire  [7:0]      dv [NDUT];
  logic [NDUT-1:0] prev_done = '0;
  exp_t            sb [NDUT][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar k = 0; k < NDUT; k++) begin : g_dut
    serial_sub_if #(.WIDTH(8)) bus ();
    serial_sub #(.WIDTH(8), .BPC(BPCS[k])) dut (.clk(clk), .rst(rst), .bus(bus));
    assign bus.start = st[k];
    assign bus.a     = av[k];
    assign bus.b     = bv[k];
    assign bus.bin   = bi[k];
    assign rdy[k]    = bus.ready;
    assign bsy[k]    = bus.busy;
    assign dn[k]     = bus.done;
    assign dv[k]     = bus.diff;
    assign bo[k]     = bus.borrow;
    assign ov[k]     = bus.ovf;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic bin, input int c);
    exp_t e;
    logic [8:0] f;
    f        = {1'b0, a} - {1'b0, b} - {8'h00, bin};
    e.diff   = f[7:0];
    e.borrow = f[8];
    e.ovf    = (a[7] != b[7]) && (f[7] != a[7]);
    e.cyc    = c;
    return e;
  endfunction

  // Monitor: flag one-hotness, ready right after done, and scoreboard pops on done.
  always @(negedge clk) begin
    exp_t e;
    for (int k = 0; k < NDUT; k++) begin
      if (armed && !rst) begin
        check($sformatf("onehot%0d", k), 32'(rdy[k]) + 32'(bsy[k]) + 32'(dn[k]), 1);
        if (prev_done[k]) check($sformatf("ready_after_done%0d", k), rdy[k], 1);
      end
      if (armed && dn[k] === 1'b1) begin
        if (sb[k].size() == 0) begin
          check($sformatf("spurious_done%0d", k), 1, 0);
        end else begin
          e = sb[k].pop_front();
          check($sformatf("diff%0d", k),    dv[k], e.diff);
          check($sformatf("borrow%0d", k),  bo[k], e.borrow);
          check($sformatf("ovf%0d", k),     ov[k], e.ovf);
          check($sformatf("latency%0d", k), cyc,   e.cyc);
        end
      end
    end
    prev_done <= dn;
  end

  task automatic start_ops(input logic [NDUT-1:0] mask, input logic [7:0] a, input logic [7:0] b,
                           input logic bin, input bit push);
    @(negedge clk);
    for (int k = 0; k < NDUT; k++) begin
      if (mask[k]) begin
        if (push) begin
          check($sformatf("ready_at_start%0d", k), rdy[k], 1);
          sb[k].push_back(model(a, b, bin, cyc + 1 + NS[k]));
        end
        st[k] = 1'b1;
        av[k] = a;
        bv[k] = b;
        bi[k] = bin;
      end
    end
    @(negedge clk);
    for (int k = 0; k < NDUT; k++) begin
      if (mask[k]) begin
        st[k] = 1'b0;
        av[k] = 8'($urandom);
        bv[k] = 8'($urandom);
        bi[k] = 1'($urandom);
      end
    end
  endtask

  function automatic bit pending(input logic [NDUT-1:0] mask);
    bit p = 1'b0;
    for (int k = 0; k < NDUT; k++) if (mask[k] && sb[k].size() != 0) p = 1'b1;
    return p;
  endfunction

  task automatic wait_idle(input logic [NDUT-1:0] mask);
    int t = 0;
    while (pending(mask) && t < 100) begin
      @(posedge clk);
      t++;
    end
    for (int k = 0; k < NDUT; k++) begin
      if (mask[k]) begin
        check($sformatf("pending%0d", k), 32'(sb[k].size()), 0);
        sb[k].delete();
      end
    end
  endtask

  task automatic op1(input logic [7:0] a, input logic [7:0] b, input logic bin);
    start_ops(3'b001, a, b, bin, 1'b1);
    wait_idle(3'b001);
  endtask

  initial begin
    logic [7:0] ra, rb;
    logic       rc;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst   = 1'b0;
    armed = 1'b1;
    check("rst_ready",  rdy[0], 1);
    check("rst_busy",   bsy[0], 0);
    check("rst_done",   dn[0],  0);
    check("rst_diff",   dv[0],  0);
    check("rst_borrow", bo[0],  0);
    check("rst_ovf",    ov[0],  0);

    op1(8'h05, 8'h03, 1'b0);
    op1(8'h03, 8'h05, 1'b0);
    op1(8'h00, 8'h00, 1'b1);
    op1(8'h80, 8'h01, 1'b0);
    op1(8'h7F, 8'hFF, 1'b0);

    // start held high mid-run must be ignored; previous result stays visible
    start_ops(3'b001, 8'h10, 8'h01, 1'b0, 1'b1);
    @(negedge clk);
    check("diff_held_in_run", dv[0], 8'h80);
    check("ovf_held_in_run",  ov[0], 1);
    st[0] = 1'b1;
    av[0] = 8'hFF;
    bv[0] = 8'h00;
    repeat (3) @(negedge clk);
    st[0] = 1'b0;
    wait_idle(3'b001);
    repeat (3) @(negedge clk);

    // reset at count 4 aborts: no done, outputs cleared
    start_ops(3'b001, 8'h55, 8'h22, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_ready",  rdy[0], 1);
    check("abort_busy",   bsy[0], 0);
    check("abort_diff",   dv[0],  0);
    check("abort_borrow", bo[0],  0);
    check("abort_ovf",    ov[0],  0);
    repeat (12) @(negedge clk);
    op1(8'h55, 8'h22, 1'b0);

    for (int c = 0; c < 8; c++) begin
      ra = {c[2], 7'($urandom)};
      rb = {c[1], 7'($urandom)};
      start_ops(3'b110, ra, rb, c[0], 1'b1);
      wait_idle(3'b110);
    end
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      start_ops(3'b110, ra, rb, rc, 1'b1);
      wait_idle(3'b110);
    end

    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
